// File: rtl/key_event_scheduler_if.sv
// Press-event handshake between the key scheduler (master) and the user logic (slave).
// event_valid/event_key follow valid/ready; event_overrun is a side pulse.
interface key_event_scheduler_if #(
  parameter int N_KEYS = 4
);
  localparam int KW = $clog2(N_KEYS);

  logic          event_valid;
  logic          event_ready;
  logic [KW-1:0] event_key;
  logic          event_overrun;

  modport master (
    output event_valid,
    output event_key,
    output event_overrun,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_key,
    input  event_overrun,
    output event_ready
  );
endinterface

// File: rtl/key_event_scheduler.sv
// Push-button front end: per-key synchroniser and debounce FSM driven by a shared tick,
// one pending press per key, and a round-robin arbiter onto a single event stream.
module key_event_scheduler #(
  parameter int N_KEYS         = 4,
  parameter int TICK_DIV       = 100_000,
  parameter int DEBOUNCE_TICKS = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_KEYS-1:0]     din,
  output logic [N_KEYS-1:0]     key_state,
  key_event_scheduler_if.master evt
);

  localparam int KW = $clog2(N_KEYS);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TC_LAST  = TW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    PRESS_DEB   = 2'b01,
    HELD        = 2'b10,
    RELEASE_DEB = 2'b11
  } key_fsm_e;

  // Synchroniser: raw pads are idle-high, so the flops reset to 1 (released).
  logic [N_KEYS-1:0] sync1_q, sync2_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  key_fsm_e          state_q [N_KEYS];
  key_fsm_e          state_d [N_KEYS];
  logic [TW-1:0]     tc_q    [N_KEYS];
  logic [TW-1:0]     tc_d    [N_KEYS];
  logic [N_KEYS-1:0] set_pend;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    set_pend = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      state_d[i] = state_q[i];
      tc_d[i]    = tc_q[i];
      case (state_q[i])
        IDLE: begin
          if (!sync2_q[i]) begin
            state_d[i] = PRESS_DEB;
            tc_d[i]    = '0;
          end
        end
        PRESS_DEB: begin
          if (sync2_q[i]) begin
            state_d[i] = IDLE;
            tc_d[i]    = '0;
          end else if (tick) begin
            if (tc_q[i] == TC_LAST) begin
              state_d[i]  = HELD;
              tc_d[i]     = '0;
              set_pend[i] = 1'b1;
            end else begin
              tc_d[i] = tc_q[i] + TW'(1);
            end
          end
        end
        HELD: begin
          if (sync2_q[i]) begin
            state_d[i] = RELEASE_DEB;
            tc_d[i]    = '0;
          end
        end
        RELEASE_DEB: begin
          if (!sync2_q[i]) begin
            state_d[i] = HELD;
            tc_d[i]    = '0;
          end else if (tick) begin
            if (tc_q[i] == TC_LAST) begin
              state_d[i] = IDLE;
              tc_d[i]    = '0;
            end else begin
              tc_d[i] = tc_q[i] + TW'(1);
            end
          end
        end
        default: begin
          state_d[i] = IDLE;
          tc_d[i]    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= IDLE;
        tc_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= state_d[i];
        tc_q[i]    <= tc_d[i];
      end
    end
  end

  always_comb begin
    key_state = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      key_state[i] = (state_q[i] == HELD) || (state_q[i] == RELEASE_DEB);
    end
  end

  logic [N_KEYS-1:0] pend_q, pend_d, grant_oh;
  logic [KW-1:0]     rr_q, rr_d, key_q, key_d, win;
  logic              valid_q, valid_d, ovr_q, ovr_d;
  logic              slot_free, found;

  always_comb begin
    grant_oh  = '0;
    found     = 1'b0;
    win       = '0;
    key_d     = key_q;
    rr_d      = rr_q;
    valid_d   = valid_q;
    slot_free = !valid_q || evt.event_ready;

    // Rotating scan: the first pending key at or after rr_q wins.
    for (int off = 0; off < N_KEYS; off++) begin
      if (!found && pend_q[(int'(rr_q) + off) % N_KEYS]) begin
        found = 1'b1;
        win   = KW'((int'(rr_q) + off) % N_KEYS);
      end
    end

    if (slot_free) begin
      if (found) begin
        valid_d       = 1'b1;
        key_d         = win;
        grant_oh[win] = 1'b1;
        rr_d          = (int'(win) == N_KEYS - 1) ? '0 : win + KW'(1);
      end else begin
        valid_d = 1'b0;
      end
    end

    // A fresh press beats a same-cycle grant of that key and is not an overrun.
    pend_d = (pend_q & ~grant_oh) | set_pend;
    ovr_d  = |(set_pend & pend_q & ~grant_oh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      rr_q    <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign evt.event_valid   = valid_q;
  assign evt.event_key     = key_q;
  assign evt.event_overrun = ovr_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Scoreboard bench for key_event_scheduler: a behavioural model predicts grants into a queue,
// a negedge monitor pops on every accepted event; directed scenarios plus a random phase.
module tb_key_event_scheduler;
  localparam int N_KEYS   = 4;
  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int KW       = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N_KEYS-1:0] din = '1;
  logic              ready_r = 1'b0;
  logic [N_KEYS-1:0] key_state;

  key_event_scheduler_if #(.N_KEYS(N_KEYS)) evt ();
  assign evt.event_ready = ready_r;

  key_event_scheduler #(
    .N_KEYS(N_KEYS), .TICK_DIV(TICK_DIV), .DEBOUNCE_TICKS(DEB)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .key_state(key_state), .evt(evt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ovr_cnt = 0;
  int acc_log [$];
  int exp_q   [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: debounced level per key, "ticks the new level has survived",
  // a pending set, and a rotating-priority pick whenever the output slot is free.
  logic [N_KEYS-1:0] m_s1, m_s2, m_stable, m_pend;
  bit                m_deb [N_KEYS];
  int                m_cnt [N_KEYS];
  int                m_pre, m_rr, m_key;
  logic              m_valid, m_ovr;

  always @(posedge clk or posedge rst) begin : model
    logic [N_KEYS-1:0] s, set;
    logic              pressed_now, tick, free;
    int                granted, j;
    if (rst) begin
      m_s1 = '1; m_s2 = '1; m_stable = '0; m_pend = '0;
      m_pre = 0; m_rr = 0; m_key = 0; m_valid = 1'b0; m_ovr = 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin m_deb[i] = 0; m_cnt[i] = 0; end
      exp_q.delete();
    end else begin
      s = m_s2; m_s2 = m_s1; m_s1 = din;
      tick  = (m_pre == TICK_DIV - 1);
      m_pre = (m_pre + 1) % TICK_DIV;
      set   = '0;
      for (int i = 0; i < N_KEYS; i++) begin
        pressed_now = !s[i];
        if (pressed_now == m_stable[i]) begin
          m_deb[i] = 0; m_cnt[i] = 0;
        end else if (!m_deb[i]) begin
          m_deb[i] = 1; m_cnt[i] = 0;
        end else if (tick) begin
          m_cnt[i]++;
          if (m_cnt[i] == DEB) begin
            m_stable[i] = pressed_now;
            m_deb[i]    = 0;
            if (pressed_now) set[i] = 1'b1;
          end
        end
      end
      free    = !m_valid || ready_r;
      granted = -1;
      if (free) begin
        for (int k = 0; k < N_KEYS; k++) begin
          j = (m_rr + k) % N_KEYS;
          if (granted < 0 && m_pend[j]) granted = j;
        end
        if (granted >= 0) begin
          m_valid = 1'b1; m_key = granted; m_rr = (granted + 1) % N_KEYS;
          exp_q.push_back(granted);
        end else begin
          m_valid = 1'b0;
        end
      end
      m_ovr = 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        if (set[i]) begin
          if (m_pend[i] && granted != i) m_ovr = 1'b1;
          m_pend[i] = 1'b1;
        end else if (granted == i) begin
          m_pend[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    int exp_key;
    if (!rst) begin
      check("key_state", 32'(key_state), 32'(m_stable));
      check("event_valid", 32'(evt.event_valid), 32'(m_valid));
      if (m_valid) check("event_key", 32'(evt.event_key), 32'(m_key));
      check("event_overrun", 32'(evt.event_overrun), 32'(m_ovr));
      if (evt.event_overrun) ovr_cnt++;
      if (evt.event_valid && evt.event_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL scoreboard_empty: got event key %0d, expected no event", evt.event_key);
        end else begin
          exp_key = exp_q.pop_front();
          check("scoreboard_key", 32'(evt.event_key), 32'(exp_key));
        end
        acc_log.push_back(int'(evt.event_key));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rst_assert();
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 32'(evt.event_valid), 32'd0);
    check("rst_key", 32'(evt.event_key), 32'd0);
    check("rst_overrun", 32'(evt.event_overrun), 32'd0);
    check("rst_key_state", 32'(key_state), 32'd0);
  endtask

  task automatic rst_release();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst_assert();
    step(2);
    rst_release();
    step(2);

    // Clean press on key 2.
    acc_log.delete();
    ready_r = 1'b1;
    din[2] = 1'b0;
    step(2);
    check("t1_state_early", 32'(key_state[2]), 32'd0);
    step(16);
    check("t1_state_rise", 32'(key_state[2]), 32'd1);
    step(22);
    din[2] = 1'b1;
    step(40);
    check("t1_state_fall", 32'(key_state[2]), 32'd0);
    check("t1_count", acc_log.size(), 1);
    check("t1_key", acc_log[0], 2);

    // Short glitch on key 1.
    acc_log.delete();
    din[1] = 1'b0;
    step(5);
    din[1] = 1'b1;
    step(30);
    check("t2_count", acc_log.size(), 0);
    check("t2_state", 32'(key_state), 32'd0);

    // Round-robin: grant key 0 first so the pointer sits at 1.
    din[0] = 1'b0; step(30); din[0] = 1'b1; step(30);
    acc_log.delete();
    ready_r = 1'b0;
    din[0] = 1'b0; din[3] = 1'b0;
    step(30);
    check("t3_valid_held", 32'(evt.event_valid), 32'd1);
    check("t3_key_held", 32'(evt.event_key), 32'd3);
    din = '1;
    step(30);
    check("t3_key_still", 32'(evt.event_key), 32'd3);
    ready_r = 1'b1;
    step(4);
    check("t3_count", acc_log.size(), 2);
    check("t3_first", acc_log[0], 3);
    check("t3_second", acc_log[1], 0);
    check("t3_idle", 32'(evt.event_valid), 32'd0);

    // Overrun: three full presses of key 1 with the consumer stalled.
    acc_log.delete();
    ovr_cnt = 0;
    ready_r = 1'b0;
    for (int p = 0; p < 3; p++) begin
      din[1] = 1'b0; step(25);
      din[1] = 1'b1; step(25);
    end
    check("t4_overrun_cycles", ovr_cnt, 1);
    ready_r = 1'b1;
    step(4);
    check("t4_count", acc_log.size(), 2);
    check("t4_first", acc_log[0], 1);
    check("t4_second", acc_log[1], 1);

    // Back-to-back from a fresh pointer.
    rst_assert(); step(2); rst_release();
    acc_log.delete();
    ready_r = 1'b1;
    din[2:0] = 3'b000;
    step(30);
    check("t5_count", acc_log.size(), 3);
    check("t5_k0", acc_log[0], 0);
    check("t5_k1", acc_log[1], 1);
    check("t5_k2", acc_log[2], 2);
    din = '1;
    step(30);
    check("t5_no_release_events", acc_log.size(), 3);

    // Reset mid-debounce with the key held throughout.
    acc_log.delete();
    din[1] = 1'b0;
    step(8);
    rst_assert(); step(3); rst_release();
    step(40);
    din[1] = 1'b1;
    step(40);
    check("t6a_count", acc_log.size(), 1);
    check("t6a_key", acc_log[0], 1);

    // Reset during a stalled handshake; keys 0,3 let go during reset, key 2 stays held.
    ready_r = 1'b0;
    din[0] = 1'b0; din[2] = 1'b0; din[3] = 1'b0;
    step(30);
    check("t6b_valid_before", 32'(evt.event_valid), 32'd1);
    rst_assert();
    din[0] = 1'b1; din[3] = 1'b1;
    step(3);
    rst_release();
    acc_log.delete();
    ready_r = 1'b1;
    step(40);
    din[2] = 1'b1;
    step(40);
    check("t6b_count", acc_log.size(), 1);
    check("t6b_key", acc_log[0], 2);

    // Random key chatter and consumer back-pressure, one reset in the middle.
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N_KEYS; k++) begin
        if ($urandom_range(15) == 0) din[k] = ~din[k];
      end
      ready_r = ($urandom_range(3) != 0) && ((c / 300) % 4 != 3);
      if (c == 2000) begin
        rst_assert(); step(2); rst_release();
      end
      step(1);
    end
    din = '1;
    ready_r = 1'b1;
    step(60);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_idle", 32'(evt.event_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
